// File: rtl/iob_ram_t2p_be_arbiter.sv
// Two-requester front end for a byte-enabled 1W/1R RAM with independent round-robin
// write and read arbitration and one-cycle read response steering.
module iob_ram_t2p_be_arbiter #(
    parameter int ADDR_W          = 10,
    parameter int DATA_W          = 32,
    parameter int COLLISION_STALL = 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                w0_valid_i,
    output logic                w0_ready_o,
    input  logic [ADDR_W-1:0]   w0_addr_i,
    input  logic [DATA_W-1:0]   w0_data_i,
    input  logic [DATA_W/8-1:0] w0_strb_i,
    input  logic                w1_valid_i,
    output logic                w1_ready_o,
    input  logic [ADDR_W-1:0]   w1_addr_i,
    input  logic [DATA_W-1:0]   w1_data_i,
    input  logic [DATA_W/8-1:0] w1_strb_i,
    input  logic                r0_valid_i,
    output logic                r0_ready_o,
    input  logic [ADDR_W-1:0]   r0_addr_i,
    output logic                r0_rvalid_o,
    output logic [DATA_W-1:0]   r0_rdata_o,
    input  logic                r1_valid_i,
    output logic                r1_ready_o,
    input  logic [ADDR_W-1:0]   r1_addr_i,
    output logic                r1_rvalid_o,
    output logic [DATA_W-1:0]   r1_rdata_o,
    output logic [DATA_W/8-1:0] ram_w_strb_o,
    output logic [ADDR_W-1:0]   ram_w_addr_o,
    output logic [DATA_W-1:0]   ram_w_data_o,
    output logic                ram_r_en_o,
    output logic [ADDR_W-1:0]   ram_r_addr_o,
    input  logic [DATA_W-1:0]   ram_r_data_i
);

    localparam bit STALL_EN = (COLLISION_STALL != 0);

    logic w_prio_q, w_prio_d;
    logic r_prio_q, r_prio_d;
    logic rpend_q, rpend_d;
    logic rsel_q, rsel_d;

    logic w_gnt0, w_gnt1, w_xfer;
    logic r_cand0, r_cand1;
    logic r_gnt0, r_gnt1, r_xfer;

    // Write side: a lone requester always wins, a tie goes to w_prio.
    assign w_gnt0 = w0_valid_i & (~w1_valid_i | ~w_prio_q);
    assign w_gnt1 = w1_valid_i & (~w0_valid_i |  w_prio_q);
    assign w_xfer = w_gnt0 | w_gnt1;

    assign w0_ready_o   = w_gnt0;
    assign w1_ready_o   = w_gnt1;
    assign ram_w_addr_o = w_gnt1 ? w1_addr_i : w0_addr_i;
    assign ram_w_data_o = w_gnt1 ? w1_data_i : w0_data_i;
    assign ram_w_strb_o = w_gnt1 ? w1_strb_i : (w_gnt0 ? w0_strb_i : '0);

    // A read hitting the address being written this cycle drops out of arbitration.
    assign r_cand0 = r0_valid_i & ~(STALL_EN & w_xfer & (r0_addr_i == ram_w_addr_o));
    assign r_cand1 = r1_valid_i & ~(STALL_EN & w_xfer & (r1_addr_i == ram_w_addr_o));

    assign r_gnt0 = r_cand0 & (~r_cand1 | ~r_prio_q);
    assign r_gnt1 = r_cand1 & (~r_cand0 |  r_prio_q);
    assign r_xfer = r_gnt0 | r_gnt1;

    assign r0_ready_o   = r_gnt0;
    assign r1_ready_o   = r_gnt1;
    assign ram_r_en_o   = r_xfer;
    assign ram_r_addr_o = r_gnt1 ? r1_addr_i : r0_addr_i;

    assign r0_rvalid_o = rpend_q & ~rsel_q;
    assign r1_rvalid_o = rpend_q &  rsel_q;
    assign r0_rdata_o  = ram_r_data_i;
    assign r1_rdata_o  = ram_r_data_i;

    always_comb begin
        w_prio_d = w_prio_q;
        r_prio_d = r_prio_q;
        rsel_d   = rsel_q;
        rpend_d  = r_xfer;
        if (w_xfer) begin
            w_prio_d = ~w_gnt1;
        end
        if (r_xfer) begin
            r_prio_d = ~r_gnt1;
            rsel_d   = r_gnt1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            w_prio_q <= 1'b0;
            r_prio_q <= 1'b0;
            rpend_q  <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            w_prio_q <= w_prio_d;
            r_prio_q <= r_prio_d;
            rpend_q  <= rpend_d;
            rsel_q   <= rsel_d;
        end
    end

endmodule

// File: tb/tb_iob_ram_t2p_be_arbiter.sv
// Directed bench: one arbiter with collision stall, one without, each in front of its own RAM model.
module tb_iob_ram_t2p_be_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    logic          w0_valid, w1_valid, r0_valid, r1_valid;
    logic [AW-1:0] w0_addr, w1_addr, r0_addr, r1_addr;
    logic [DW-1:0] w0_data, w1_data;
    logic [3:0]    w0_strb, w1_strb;

    // Instance a: COLLISION_STALL = 1
    logic          a_w0_ready, a_w1_ready, a_r0_ready, a_r1_ready;
    logic          a_r0_rvalid, a_r1_rvalid, a_r_en;
    logic [DW-1:0] a_r0_rdata, a_r1_rdata, a_w_data, a_r_data;
    logic [AW-1:0] a_w_addr, a_r_addr;
    logic [3:0]    a_w_strb;
    // Instance b: COLLISION_STALL = 0
    logic          b_w0_ready, b_w1_ready, b_r0_ready, b_r1_ready;
    logic          b_r0_rvalid, b_r1_rvalid, b_r_en;
    logic [DW-1:0] b_r0_rdata, b_r1_rdata, b_w_data, b_r_data;
    logic [AW-1:0] b_w_addr, b_r_addr;
    logic [3:0]    b_w_strb;

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];

    iob_ram_t2p_be_arbiter #(.ADDR_W(AW), .DATA_W(DW), .COLLISION_STALL(1)) dut_a (
        .clk_i(clk), .arst_n_i(arst_n),
        .w0_valid_i(w0_valid), .w0_ready_o(a_w0_ready), .w0_addr_i(w0_addr), .w0_data_i(w0_data), .w0_strb_i(w0_strb),
        .w1_valid_i(w1_valid), .w1_ready_o(a_w1_ready), .w1_addr_i(w1_addr), .w1_data_i(w1_data), .w1_strb_i(w1_strb),
        .r0_valid_i(r0_valid), .r0_ready_o(a_r0_ready), .r0_addr_i(r0_addr), .r0_rvalid_o(a_r0_rvalid), .r0_rdata_o(a_r0_rdata),
        .r1_valid_i(r1_valid), .r1_ready_o(a_r1_ready), .r1_addr_i(r1_addr), .r1_rvalid_o(a_r1_rvalid), .r1_rdata_o(a_r1_rdata),
        .ram_w_strb_o(a_w_strb), .ram_w_addr_o(a_w_addr), .ram_w_data_o(a_w_data),
        .ram_r_en_o(a_r_en), .ram_r_addr_o(a_r_addr), .ram_r_data_i(a_r_data)
    );

    iob_ram_t2p_be_arbiter #(.ADDR_W(AW), .DATA_W(DW), .COLLISION_STALL(0)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n),
        .w0_valid_i(w0_valid), .w0_ready_o(b_w0_ready), .w0_addr_i(w0_addr), .w0_data_i(w0_data), .w0_strb_i(w0_strb),
        .w1_valid_i(w1_valid), .w1_ready_o(b_w1_ready), .w1_addr_i(w1_addr), .w1_data_i(w1_data), .w1_strb_i(w1_strb),
        .r0_valid_i(r0_valid), .r0_ready_o(b_r0_ready), .r0_addr_i(r0_addr), .r0_rvalid_o(b_r0_rvalid), .r0_rdata_o(b_r0_rdata),
        .r1_valid_i(r1_valid), .r1_ready_o(b_r1_ready), .r1_addr_i(r1_addr), .r1_rvalid_o(b_r1_rvalid), .r1_rdata_o(b_r1_rdata),
        .ram_w_strb_o(b_w_strb), .ram_w_addr_o(b_w_addr), .ram_w_data_o(b_w_data),
        .ram_r_en_o(b_r_en), .ram_r_addr_o(b_r_addr), .ram_r_data_i(b_r_data)
    );

    // Byte-enabled RAM models, read-before-write on a same-address collision.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (a_w_strb[i]) mem_a[a_w_addr][8*i +: 8] <= a_w_data[8*i +: 8];
            if (b_w_strb[i]) mem_b[b_w_addr][8*i +: 8] <= b_w_data[8*i +: 8];
        end
        if (a_r_en) a_r_data <= mem_a[a_r_addr];
        if (b_r_en) b_r_data <= mem_b[b_r_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_valid = 1'b0; w1_valid = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        idle();
        w0_addr = '0; w1_addr = '0; r0_addr = '0; r1_addr = '0;
        w0_data = '0; w1_data = '0; w0_strb = '0; w1_strb = '0;
        arst_n = 1'b0;
        #2;
        check("rst_w0_ready", a_w0_ready, 0);
        check("rst_w1_ready", a_w1_ready, 0);
        check("rst_r0_ready", a_r0_ready, 0);
        check("rst_r1_ready", a_r1_ready, 0);
        check("rst_w_strb",   a_w_strb,   0);
        check("rst_r_en",     a_r_en,     0);
        check("rst_r0_rvalid", a_r0_rvalid, 0);
        check("rst_r1_rvalid", a_r1_rvalid, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;

        // 1: write tie alternates w0,w1,w0,w1
        w0_valid = 1; w0_addr = 0; w0_data = 32'hA0; w0_strb = 4'hF;
        w1_valid = 1; w1_addr = 1; w1_data = 32'hA1; w1_strb = 4'hF;
        #1; check("t1_c0_w0", a_w0_ready, 1); check("t1_c0_w1", a_w1_ready, 0);
        tick(); w0_addr = 2; w0_data = 32'hA2;
        #1; check("t1_c1_w0", a_w0_ready, 0); check("t1_c1_w1", a_w1_ready, 1);
        tick(); w1_addr = 3; w1_data = 32'hA3;
        #1; check("t1_c2_w0", a_w0_ready, 1); check("t1_c2_w1", a_w1_ready, 0);
        tick();
        #1; check("t1_c3_w0", a_w0_ready, 0); check("t1_c3_w1", a_w1_ready, 1);
        tick(); idle();
        for (int k = 0; k < 4; k++) check($sformatf("t1_mem%0d", k), mem_a[k], 32'hA0 + k);

        // 2: partial-strobe write then read back through r1
        w1_valid = 1; w1_addr = 3; w1_data = 32'h11223344; w1_strb = 4'hF;
        #1; check("t2_w1_alone", a_w1_ready, 1);
        tick(); idle();
        w0_valid = 1; w0_addr = 3; w0_data = 32'hAABBCCDD; w0_strb = 4'b0100;
        #1; check("t2_w0_ready", a_w0_ready, 1); check("t2_w_strb", a_w_strb, 4'b0100);
        tick(); idle();
        r1_valid = 1; r1_addr = 3;
        #1; check("t2_r1_ready", a_r1_ready, 1); check("t2_r_en", a_r_en, 1);
        tick(); r1_valid = 0;
        #1; check("t2_r1_rvalid", a_r1_rvalid, 1); check("t2_r1_rdata", a_r1_rdata, 32'h11BB3344);
        check("t2_r0_rvalid", a_r0_rvalid, 0);
        tick();
        check("t2_r1_rvalid_drop", a_r1_rvalid, 0);

        // 3: read tie after reset, r0 first
        w0_valid = 1; w0_addr = 4; w0_data = 32'h44444444; w0_strb = 4'hF;
        tick(); w0_addr = 5; w0_data = 32'h55555555;
        tick(); idle();
        do_reset();
        r0_valid = 1; r0_addr = 4; r1_valid = 1; r1_addr = 5;
        #1; check("t3_r0_first", a_r0_ready, 1); check("t3_r1_wait", a_r1_ready, 0);
        tick(); r0_valid = 0;
        #1; check("t3_r0_rvalid", a_r0_rvalid, 1); check("t3_r0_rdata", a_r0_rdata, 32'h44444444);
        check("t3_r1_rvalid0", a_r1_rvalid, 0); check("t3_r1_ready", a_r1_ready, 1);
        tick(); r1_valid = 0;
        #1; check("t3_r1_rvalid", a_r1_rvalid, 1); check("t3_r1_rdata", a_r1_rdata, 32'h55555555);
        check("t3_r0_rvalid0", a_r0_rvalid, 0);
        tick();

        // 4: read/write collision on addr 5
        w0_valid = 1; w0_addr = 5; w0_data = 32'h0; w0_strb = 4'hF;
        tick();
        w0_data = 32'h0000CAFE; r1_valid = 1; r1_addr = 5;
        #1; check("t4_stall_r1_ready", a_r1_ready, 0); check("t4_stall_r_en", a_r_en, 0);
        check("t4_nostall_r1_ready", b_r1_ready, 1); check("t4_w0_ready", a_w0_ready, 1);
        tick(); w0_valid = 0;
        #1; check("t4_stall_r1_ready2", a_r1_ready, 1); check("t4_stall_no_rvalid", a_r1_rvalid, 0);
        check("t4_nostall_rvalid", b_r1_rvalid, 1); check("t4_nostall_rdata", b_r1_rdata, 32'h0);
        tick(); r1_valid = 0;
        #1; check("t4_stall_rvalid", a_r1_rvalid, 1); check("t4_stall_rdata", a_r1_rdata, 32'h0000CAFE);
        tick();

        // 5: reset right after an accepted read
        w0_valid = 1; w0_addr = 8; w0_data = 32'h88; w0_strb = 4'hF;
        r0_valid = 1; r0_addr = 4;
        #1; check("t5_r0_ready", a_r0_ready, 1);
        @(posedge clk); #1;
        arst_n = 1'b0; idle();
        #1; check("t5_rvalid_in_rst", a_r0_rvalid, 0);
        @(posedge clk); #1;
        check("t5_rvalid_in_rst2", a_r0_rvalid, 0);
        arst_n = 1'b1;
        w0_valid = 1; w0_addr = 11; w1_valid = 1; w1_addr = 12;
        r0_valid = 1; r0_addr = 4;  r1_valid = 1; r1_addr = 5;
        #1; check("t5_w0_tie", a_w0_ready, 1); check("t5_w1_tie", a_w1_ready, 0);
        check("t5_r0_tie", a_r0_ready, 1); check("t5_r1_tie", a_r1_ready, 0);
        tick(); idle();

        // 6: lone w1, then tie to w0 with zero strobe
        w1_valid = 1; w1_addr = 9; w1_data = 32'h99999999; w1_strb = 4'hF;
        #1; check("t6_w1_alone", a_w1_ready, 1);
        tick();
        w1_addr = 10; w1_data = 32'h10101010;
        w0_valid = 1; w0_addr = 9; w0_data = 32'hFFFFFFFF; w0_strb = 4'h0;
        #1; check("t6_w0_tie", a_w0_ready, 1); check("t6_w1_tie", a_w1_ready, 0);
        check("t6_w_strb0", a_w_strb, 0);
        tick(); idle();
        r0_valid = 1; r0_addr = 9;
        #1; check("t6_r0_ready", a_r0_ready, 1);
        tick(); r0_valid = 0;
        #1; check("t6_r0_rvalid", a_r0_rvalid, 1); check("t6_r0_rdata", a_r0_rdata, 32'h99999999);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
